// File: rtl/fullsub_pkg.sv
// Shared definitions for the ripple-borrow subtractor: default operand width
// and the coding-style selector used to build the three parallel chains.
package fullsub_pkg;

    localparam int WIDTH_DEFAULT = 1;

    // Which body a fullsub_cell elaborates.
    typedef enum logic [1:0] {
        STYLE_GATE     = 2'd0,
        STYLE_DATAFLOW = 2'd1,
        STYLE_BEHAV    = 2'd2
    } style_e;

endpackage

// File: rtl/fullsub_cell.sv
// 1-bit full subtractor: d = a ^ b ^ bi, bo = (~a & b) | (~(a ^ b) & bi).
// The same function is written as gate primitives, continuous assigns or a
// truth-table case, chosen by STYLE, so the chains can cross-check each other.
module fullsub_cell
    import fullsub_pkg::*;
#(
    parameter style_e STYLE = STYLE_DATAFLOW
) (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    generate
        if (STYLE == STYLE_GATE) begin : g_gate
            logic a_n, axb, axb_n, t_ab, t_bi;
            not u_not_a   (a_n, a);
            xor u_xor_ab  (axb, a, b);
            xor u_xor_d   (d, axb, bi);
            not u_not_axb (axb_n, axb);
            and u_and_ab  (t_ab, a_n, b);
            and u_and_bi  (t_bi, axb_n, bi);
            or  u_or_bo   (bo, t_ab, t_bi);
        end else if (STYLE == STYLE_BEHAV) begin : g_behav
            // Truth table of a - b - bi, written out row by row.
            always_comb begin
                d  = 1'b0;
                bo = 1'b0;
                case ({a, b, bi})
                    3'b000: begin d = 1'b0; bo = 1'b0; end
                    3'b001: begin d = 1'b1; bo = 1'b1; end
                    3'b010: begin d = 1'b1; bo = 1'b1; end
                    3'b011: begin d = 1'b0; bo = 1'b1; end
                    3'b100: begin d = 1'b1; bo = 1'b0; end
                    3'b101: begin d = 1'b0; bo = 1'b0; end
                    3'b110: begin d = 1'b0; bo = 1'b0; end
                    3'b111: begin d = 1'b1; bo = 1'b1; end
                    default: begin d = 1'b0; bo = 1'b0; end
                endcase
            end
        end else begin : g_dataflow
            assign d  = a ^ b ^ bi;
            assign bo = (~a & b) | (~(a ^ b) & bi);
        end
    endgenerate

endmodule

// File: rtl/fullsub_unit.sv
// Registered WIDTH-bit ripple-borrow subtractor: {bout,d} = a - b - bin.
// Three independent ripple chains (gate, dataflow, behavioural) are built;
// the dataflow chain drives the result and any disagreement sets mismatch.
//
// Handshake: valid is a one-cycle strobe in the cycle after an en cycle;
// d/bout/mismatch are meaningful while valid is high and hold otherwise.
// There is no back-pressure.
module fullsub_unit
    import fullsub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             valid,
    output logic             mismatch
);

    // Per-chain differences and borrow nets; borrow index i is the borrow into bit i.
    logic [WIDTH-1:0] d_gate, d_flow, d_behav;
    logic [WIDTH:0]   br_gate, br_flow, br_behav;
    logic             mismatch_c;

    assign br_gate[0]  = bin;
    assign br_flow[0]  = bin;
    assign br_behav[0] = bin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            fullsub_cell #(.STYLE(STYLE_GATE)) u_gate (
                .a  (a[i]),
                .b  (b[i]),
                .bi (br_gate[i]),
                .d  (d_gate[i]),
                .bo (br_gate[i+1])
            );
            fullsub_cell #(.STYLE(STYLE_DATAFLOW)) u_flow (
                .a  (a[i]),
                .b  (b[i]),
                .bi (br_flow[i]),
                .d  (d_flow[i]),
                .bo (br_flow[i+1])
            );
            fullsub_cell #(.STYLE(STYLE_BEHAV)) u_behav (
                .a  (a[i]),
                .b  (b[i]),
                .bi (br_behav[i]),
                .d  (d_behav[i]),
                .bo (br_behav[i+1])
            );
        end
    endgenerate

    // Any chain disagreeing with the dataflow reference on d or borrow-out.
    assign mismatch_c = (d_gate != d_flow) || (d_behav != d_flow) ||
                        (br_gate[WIDTH] != br_flow[WIDTH]) ||
                        (br_behav[WIDTH] != br_flow[WIDTH]);

    // Output register: reset clears, en loads a new result, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            d        <= '0;
            bout     <= 1'b0;
            valid    <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                d        <= d_flow;
                bout     <= br_flow[WIDTH];
                mismatch <= mismatch_c;
            end
        end
    end

endmodule

// File: tb/tb_fullsub_unit.sv
// Bench for fullsub_unit at WIDTH=1, 8 and 4. Drivers push the expected
// {bout,d} into per-instance queues; monitors pop on valid and compare.
module tb_fullsub_unit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- DUT signals ----------------
    logic       en1, a1, b1, bin1, d1, bout1, valid1, mm1;
    logic       en8, bin8, bout8, valid8, mm8;
    logic [7:0] a8, b8, d8;
    logic       en4, bin4, bout4, valid4, mm4;
    logic [3:0] a4, b4, d4;

    fullsub_unit #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .en(en1), .a(a1), .b(b1), .bin(bin1),
        .d(d1), .bout(bout1), .valid(valid1), .mismatch(mm1)
    );
    fullsub_unit #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .en(en8), .a(a8), .b(b8), .bin(bin8),
        .d(d8), .bout(bout8), .valid(valid8), .mismatch(mm8)
    );
    fullsub_unit #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .en(en4), .a(a4), .b(b4), .bin(bin4),
        .d(d4), .bout(bout4), .valid(valid4), .mismatch(mm4)
    );

    // ---------------- scoreboard ----------------
    logic [1:0] exp1_q[$];
    logic [8:0] exp8_q[$];
    logic [4:0] exp4_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: valid with empty expected queue at %0t", name, $time);
    endtask

    // Monitor for WIDTH=1 instance.
    always @(negedge clk) begin
        if (valid1 === 1'b1) begin
            if (exp1_q.size() == 0) unexpected("w1_result");
            else begin
                check("w1_result", {30'd0, bout1, d1}, {30'd0, exp1_q.pop_front()});
                check("w1_mismatch", {31'd0, mm1}, 32'd0);
            end
        end
    end

    // Monitor for WIDTH=8 instance.
    always @(negedge clk) begin
        if (valid8 === 1'b1) begin
            if (exp8_q.size() == 0) unexpected("w8_result");
            else begin
                check("w8_result", {23'd0, bout8, d8}, {23'd0, exp8_q.pop_front()});
                check("w8_mismatch", {31'd0, mm8}, 32'd0);
            end
        end
    end

    // Monitor for WIDTH=4 instance.
    always @(negedge clk) begin
        if (valid4 === 1'b1) begin
            if (exp4_q.size() == 0) unexpected("w4_result");
            else begin
                check("w4_result", {27'd0, bout4, d4}, {27'd0, exp4_q.pop_front()});
                check("w4_mismatch", {31'd0, mm4}, 32'd0);
            end
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic drive1(input logic a, input logic b, input logic bin, input logic [1:0] exp);
        a1 = a; b1 = b; bin1 = bin; en1 = 1'b1;
        exp1_q.push_back(exp);
        @(negedge clk);
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic bin, input logic [8:0] exp);
        a8 = a; b8 = b; bin8 = bin; en8 = 1'b1;
        exp8_q.push_back(exp);
        @(negedge clk);
    endtask

    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic bin, input logic [4:0] exp);
        a4 = a; b4 = b; bin4 = bin; en4 = 1'b1;
        exp4_q.push_back(exp);
        @(negedge clk);
    endtask

    // WIDTH=1 truth table, entries {a, b, bin, exp_bout, exp_d}.
    logic [4:0] tt1 [8] = '{
        5'b100_01, 5'b110_00, 5'b000_00, 5'b010_11,
        5'b101_00, 5'b111_11, 5'b001_11, 5'b011_10
    };

    // WIDTH=8 vectors, entries {a, b, bin, exp {bout,d}}.
    logic [25:0] tt8 [5] = '{
        {8'h50, 8'h20, 1'b0, 9'h030},
        {8'h00, 8'h00, 1'b1, 9'h1FF},
        {8'h10, 8'h11, 1'b0, 9'h1FF},
        {8'hA5, 8'hA5, 1'b0, 9'h000},
        {8'hFF, 8'h00, 1'b0, 9'h0FF}
    };

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [4:0]  e1;
        logic [25:0] e8;
        logic [4:0]  e4;
        int          r;

        rst = 1'b1;
        en1 = 1'b1; a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
        en8 = 1'b1; a8 = 8'h50; b8 = 8'h20; bin8 = 1'b0;
        en4 = 1'b1; a4 = 4'h9; b4 = 4'h2; bin4 = 1'b1;

        // Reset held two cycles with en high: everything must be cleared.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_d1",     {31'd0, d1},     32'd0);
        check("rst_bout1",  {31'd0, bout1},  32'd0);
        check("rst_valid1", {31'd0, valid1}, 32'd0);
        check("rst_mm1",    {31'd0, mm1},    32'd0);
        check("rst_d8",     {24'd0, d8},     32'd0);
        check("rst_bout8",  {31'd0, bout8},  32'd0);
        check("rst_valid8", {31'd0, valid8}, 32'd0);
        check("rst_mm8",    {31'd0, mm8},    32'd0);
        check("rst_d4",     {28'd0, d4},     32'd0);
        check("rst_bout4",  {31'd0, bout4},  32'd0);
        check("rst_valid4", {31'd0, valid4}, 32'd0);
        check("rst_mm4",    {31'd0, mm4},    32'd0);

        // Release reset with en low: no result appears.
        rst = 1'b0; en1 = 1'b0; en8 = 1'b0; en4 = 1'b0;
        @(negedge clk);
        check("idle_valid1", {31'd0, valid1}, 32'd0);
        check("idle_valid8", {31'd0, valid8}, 32'd0);
        check("idle_valid4", {31'd0, valid4}, 32'd0);

        // WIDTH=1 truth table, bin=0 then bin=1.
        for (int k = 0; k < 8; k++) begin
            e1 = tt1[k];
            drive1(e1[4], e1[3], e1[2], e1[1:0]);
        end
        en1 = 1'b0;

        // WIDTH=8 directed arithmetic and boundaries.
        for (int k = 0; k < 5; k++) begin
            e8 = tt8[k];
            drive8(e8[25:18], e8[17:10], e8[9], e8[8:0]);
        end

        // Hold: load 5-3, then drop en and change inputs.
        drive8(8'h05, 8'h03, 1'b0, 9'h002);
        en8 = 1'b0; a8 = 8'hF0; b8 = 8'h0F; bin8 = 1'b1;
        @(negedge clk);
        check("hold_valid8_a", {31'd0, valid8}, 32'd0);
        check("hold_d8_a",     {24'd0, d8},     32'h02);
        check("hold_bout8_a",  {31'd0, bout8},  32'd0);
        @(negedge clk);
        check("hold_valid8_b", {31'd0, valid8}, 32'd0);
        check("hold_d8_b",     {24'd0, d8},     32'h02);

        // WIDTH=4 exhaustive sweep.
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int cv = 0; cv < 2; cv++) begin
                    r  = av - bv - cv;
                    e4 = r[4:0];
                    drive4(av[3:0], bv[3:0], cv[0], e4);
                end
            end
        end

        // Simultaneous rst and en clears the outputs.
        rst = 1'b1; en4 = 1'b1; a4 = 4'h7; b4 = 4'h1; bin4 = 1'b0;
        @(negedge clk);
        check("rsten_d4",     {28'd0, d4},     32'd0);
        check("rsten_bout4",  {31'd0, bout4},  32'd0);
        check("rsten_valid4", {31'd0, valid4}, 32'd0);
        check("rsten_mm4",    {31'd0, mm4},    32'd0);
        rst = 1'b0; en4 = 1'b0;

        // Drain: every expected response must have been consumed.
        repeat (3) @(negedge clk);
        check("drain_w1", exp1_q.size(), 32'd0);
        check("drain_w8", exp8_q.size(), 32'd0);
        check("drain_w4", exp4_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
